// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline bundle: decode-side control word and operands (D)
// and their registered execute-side copies (E).
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
);
  logic [1:0]            ResultSrcD, ResultSrcE;
  logic [1:0]            MemWriteD,  MemWriteE;
  logic                  ALUSrcD,    ALUSrcE;
  logic [2:0]            RegWriteD,  RegWriteE;
  logic [2:0]            ImmSrcD;
  logic [2:0]            ALUControlD, ALUControlE;
  logic [2:0]            funct3D,    funct3E;
  logic                  JumpD,      JumpE;
  logic                  BranchD,    BranchE;
  logic [DATA_WIDTH-1:0] RD1D,       RD1E;
  logic [DATA_WIDTH-1:0] RD2D,       RD2E;
  logic [DATA_WIDTH-1:0] PCD,        PCE;
  logic [DATA_WIDTH-1:0] PCPlus4D,   PCPlus4E;
  logic [DATA_WIDTH-1:0] ImmExtD,    ImmExtE;
  logic [REG_ADDR-1:0]   Rs1D,       Rs1E;
  logic [REG_ADDR-1:0]   Rs2D,       Rs2E;
  logic [REG_ADDR-1:0]   RdD,        RdE;
  logic                  ValidE;

  // Decode side drives D and observes E.
  modport master (
    output ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, ImmSrcD, ALUControlD, funct3D,
           JumpD, BranchD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  ResultSrcE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE, funct3E,
           JumpE, BranchE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE
  );

  // Pipeline register consumes D and produces E.
  modport slave (
    input  ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, ImmSrcD, ALUControlD, funct3D,
           JumpD, BranchD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output ResultSrcE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE, funct3E,
           JumpE, BranchE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold_i,
  input  logic                 flush_i,
  id_ex_stage_if.slave         bus,
  output logic                 StallF,
  output logic                 StallD,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [1:0]            result_src;
    logic [1:0]            mem_write;
    logic                  alu_src;
    logic [2:0]            reg_write;
    logic [2:0]            alu_control;
    logic [2:0]            funct3;
    logic                  jump;
    logic                  branch;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [REG_ADDR-1:0]   rs1;
    logic [REG_ADDR-1:0]   rs2;
    logic [REG_ADDR-1:0]   rd;
  } ex_word_t;

  ex_word_t             ex_d, ex_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;
  logic                 load_use;
  logic                 insert_bubble;

  // Only the load currently in EX can create a hazard; later stages forward.
  assign load_use = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.reg_write != '0) &&
                    (ex_q.rd != '0) && ((ex_q.rd == bus.Rs1D) || (ex_q.rd == bus.Rs2D));

  assign insert_bubble = flush_i || load_use;

  // A flushed D instruction is wrong-path, so it is not worth holding.
  assign StallF = (load_use && !flush_i) || hold_i;
  assign StallD = StallF;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!hold_i) begin
      if (insert_bubble) begin
        ex_d         = '0;
        bubble_cnt_d = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + 1'b1;
      end else begin
        ex_d.valid       = 1'b1;
        ex_d.result_src  = bus.ResultSrcD;
        ex_d.mem_write   = bus.MemWriteD;
        ex_d.alu_src     = bus.ALUSrcD;
        ex_d.reg_write   = bus.RegWriteD;
        ex_d.alu_control = bus.ALUControlD;
        ex_d.funct3      = bus.funct3D;
        ex_d.jump        = bus.JumpD;
        ex_d.branch      = bus.BranchD;
        ex_d.rd1         = bus.RD1D;
        ex_d.rd2         = bus.RD2D;
        ex_d.pc          = bus.PCD;
        ex_d.pc_plus4    = bus.PCPlus4D;
        ex_d.imm_ext     = bus.ImmExtD;
        ex_d.rs1         = bus.Rs1D;
        ex_d.rs2         = bus.Rs2D;
        ex_d.rd          = bus.RdD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ValidE      = ex_q.valid;
  assign bus.ResultSrcE  = ex_q.result_src;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.ALUControlE = ex_q.alu_control;
  assign bus.funct3E     = ex_q.funct3;
  assign bus.JumpE       = ex_q.jump;
  assign bus.BranchE     = ex_q.branch;
  assign bus.RD1E        = ex_q.rd1;
  assign bus.RD2E        = ex_q.rd2;
  assign bus.PCE         = ex_q.pc;
  assign bus.PCPlus4E    = ex_q.pc_plus4;
  assign bus.ImmExtE     = ex_q.imm_ext;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.RdE         = ex_q.rd;
  assign bubble_cnt      = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage pipelined core. It captures the decode-stage control word produced by the control unit, along with operands and register indices, and presents them to the execute stage. It also owns load-use hazard detection, inserting a one-cycle bubble and stalling fetch/decode. It handles branch/jump flushes and a global freeze, and keeps a saturating bubble counter for performance monitoring.

## Interface
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_ADDR, 5, register index width
- CNT_WIDTH, 16, bubble counter width
---
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock domain
- hold_i  input  1  global freeze (e.g. memory wait); EX register keeps its value
- flush_i  input  1  branch/jump taken in EX; next EX content is a bubble
- ResultSrcD  input  2  01 = load result
- MemWriteD  input  2  non-zero = store
- ALUSrcD  input  1
- RegWriteD  input  3  non-zero = register write
- ImmSrcD  input  3  not registered; hazard logic does not use it
- ALUControlD, funct3D  input  3 each
- JumpD, BranchD  input  1 each
- RD1D, RD2D, PCD, PCPlus4D, ImmExtD  input  DATA_WIDTH each
- Rs1D, Rs2D, RdD  input  REG_ADDR each
- *E outputs  output  same widths  registered copies of every D input above except ImmSrcD
- ValidE  output  1  EX holds a real instruction
- StallF, StallD  output  1 each  hold PC and the IF/ID register
- bubble_cnt  output  CNT_WIDTH  saturating count of inserted bubbles

## Operation
- **Load-use hazard (combinational):**
  - lu = ValidE & (ResultSrcE==01) & (RegWriteE!=0) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - Only the D-side hazard is considered; hazards against MEM/WB are resolved by forwarding elsewhere.
- **Stall outputs:** StallF = StallD = (lu & ~flush_i) | hold_i.
- **Per-edge update, priority order:**
  1. hold_i = 1: every E register and ValidE keep their value; counter unchanged.
  2. flush_i = 1: load a bubble; counter +1.
  3. lu = 1: load a bubble; counter +1.
  4. Otherwise: capture all D inputs; ValidE ← 1.
- **Bubble contents:**
  - ValidE = 0 and RegWriteE = 0, MemWriteE = 0, JumpE = 0, BranchE = 0, ResultSrcE = 00.
  - All data/index fields are cleared to 0.
  - A bubble must never write a register or memory and must never redirect the PC.
- **Counter:** bubble_cnt increments by exactly 1 per bubble and saturates at all-ones; it never wraps.
- **Reset (asynchronous assert, synchronous-looking release):**
  - Every E output is 0 and ValidE = 0, so the first EX content is a bubble.
  - bubble_cnt = 0.
  - StallF/StallD follow the combinational equation, which gives 0 while reset holds with hold_i = 0.
- Asserting reset mid-stall or mid-flush immediately clears state; there is no pending-bubble memory.

## Timing
- Latency: D inputs appear on E outputs 1 cycle after the capturing edge.
- A load-use hazard produces exactly one bubble:
  - In the hazard cycle, EX holds the load and lu = 1.
  - Next cycle, the load has moved to MEM, EX holds a bubble, so lu = 0 and the held D instruction is captured on the following edge.
- Flush and lu in the same cycle: flush wins. Stalls are deasserted because the D instruction is wrong-path. Counter +1, not +2.
- hold_i with flush_i or lu: hold wins. The flush/bubble takes effect on the first edge where hold_i = 0, provided the requester still asserts it.
- Outputs are glitch-free registers, except StallF/StallD, which are combinational from E registers, flush_i and hold_i.

## Test plan
- **Reset mid-operation:** assert rst_n = 0 asynchronously between edges while ValidE = 1 and RegWriteE = 3'b001 → outputs are 0 before the next edge; bubble_cnt = 0.
- **Pass-through:** drive RdD = 5, RegWriteD = 001, ALUControlD = 010, RD1D = 0x1234 → one edge later RdE = 5, RD1E = 0x1234, ValidE = 1, stalls 0.
- **Load-use:**
  - Setup: load in EX with RdE = 7, ResultSrcE = 01; D has Rs2D = 7 → StallF = StallD = 1 this cycle.
  - Next cycle: ValidE = 0, RegWriteE = 0, bubble_cnt = 1, stalls drop.
  - Following edge: the D instruction is captured.
- **Load to x0:** RdE = 0 with Rs1D = 0 → no stall, no bubble.
- **Flush + load-use together:** flush_i = 1 with lu true → StallD = 0, next ValidE = 0, bubble_cnt increments by exactly 1.
- **Hold and saturation:**
  - Under hold_i = 1 for 3 cycles with changing D inputs → E outputs frozen, counter frozen.
  - Preload bubble_cnt to 0xFFFF via repeated flushes → further flushes leave it at 0xFFFF.
